// File: rtl/display_pkg.sv
// display_pkg: shared 7-segment constants (active-low encoding).
// Segment bit order: bit0=a .. bit6=g.
package display_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Indexed by hex digit; entry 0 is the rightmost group.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/display_controller_if.sv
// display_if: digit producer -> display controller bundle.
// DispVal: hex digit; updated: capture strobe (rising edge pushes).
interface display_if;

  logic [3:0] DispVal;
  logic       updated;

  modport master (
    output DispVal,
    output updated
  );

  modport slave (
    input DispVal,
    input updated
  );

endinterface

// File: rtl/display_controller_seg7_decoder.sv
// seg7_decoder: combinational hex digit -> 7-segment pattern.
// Ports: digit_i (4b) in, seg_o (7b) out; polarity set by ACTIVE_LOW.
module seg7_decoder
  import display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o
);

  // Every 4-bit index hits a table entry, so no default path exists.
  always_comb begin
    seg_o = SEG_LUT[digit_i];
    if (!ACTIVE_LOW) seg_o = ~SEG_LUT[digit_i];
  end

endmodule

// File: rtl/display_controller.sv
// display_controller: current-digit segments plus a DIGITS-deep history.
// Ports: clk, rst (sync, high), disp (DispVal/updated), segOut, out_seg.
module display_controller
  import display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  display_if.slave              disp,
  output logic [SEG_W-1:0]      segOut,
  output logic [SEG_W*DIGITS-1:0] out_seg
);

  localparam int HW = SEG_W * DIGITS;

  localparam logic [SEG_W-1:0] SEG_OFF =
    ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [SEG_W-1:0] dec;
  logic             upd_q, upd_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [HW-1:0]    shifted;
  logic             push;

  seg7_decoder #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .digit_i (disp.DispVal),
    .seg_o   (dec)
  );

  // upd_q resets high so a strobe already high at reset release
  // is not mistaken for a fresh edge.
  assign push = disp.updated & ~upd_q;

  generate
    if (DIGITS > 1) begin : g_multi
      assign shifted = {hist_q[HW-SEG_W-1:0], dec};
    end else begin : g_single
      assign shifted = dec;
    end
  endgenerate

  always_comb begin
    upd_d  = disp.updated;
    seg_d  = dec;
    hist_d = hist_q;
    if (push) hist_d = shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q  <= 1'b1;
      seg_q  <= SEG_OFF;
      hist_q <= {DIGITS{SEG_OFF}};
    end else begin
      upd_q  <= upd_d;
      seg_q  <= seg_d;
      hist_q <= hist_d;
    end
  end

  assign segOut  = seg_q;
  assign out_seg = hist_q;

endmodule

// File: tb/tb_display_controller.sv
// tb_display_controller: directed stimulus, queue-based reference model,
// per-cycle comparison plus literal checkpoints.
module tb_display_controller;

  logic        clk;
  logic        rst;
  logic [6:0]  segOut;
  logic [27:0] out_seg;

  display_if dif ();

  display_controller #(
    .DIGITS     (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp    (dif),
    .segOut  (segOut),
    .out_seg (out_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [6:0] ref_lut [16];

  initial begin
    ref_lut[0]  = 7'b1000000;
    ref_lut[1]  = 7'b1111001;
    ref_lut[2]  = 7'b0100100;
    ref_lut[3]  = 7'b0110000;
    ref_lut[4]  = 7'b0011001;
    ref_lut[5]  = 7'b0010010;
    ref_lut[6]  = 7'b0000010;
    ref_lut[7]  = 7'b1111000;
    ref_lut[8]  = 7'b0000000;
    ref_lut[9]  = 7'b0010000;
    ref_lut[10] = 7'b0001000;
    ref_lut[11] = 7'b0000011;
    ref_lut[12] = 7'b1000110;
    ref_lut[13] = 7'b0100001;
    ref_lut[14] = 7'b0000110;
    ref_lut[15] = 7'b0001110;
  end

  task automatic check28(input string nm,
                         input logic [27:0] act,
                         input logic [27:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check7(input string nm,
                        input logic [6:0] act,
                        input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Model: list of captured digits, newest first.
  logic [3:0] hq[$];
  logic [6:0] m_seg;
  logic       m_prev;
  logic       m_live;
  logic       chk_en;

  initial begin
    m_live = 1'b0;
    m_prev = 1'b1;
    m_seg  = 7'h7F;
  end

  function automatic logic [27:0] model_hist();
    logic [27:0] v;
    v = 28'hFFFFFFF;
    for (int i = 0; i < 4; i++)
      if (i < hq.size()) v[i*7 +: 7] = ref_lut[hq[i]];
    return v;
  endfunction

  always @(posedge clk) begin
    logic       r, u;
    logic [3:0] d;
    r = rst;
    u = dif.updated;
    d = dif.DispVal;
    if (r) begin
      m_seg  = 7'h7F;
      hq.delete();
      m_prev = 1'b1;
      m_live = 1'b1;
    end else if (m_live) begin
      m_seg = ref_lut[d];
      if (u && !m_prev) begin
        hq.push_front(d);
        if (hq.size() > 4) void'(hq.pop_back());
      end
      m_prev = u;
    end
    #1;
    if (m_live && chk_en) begin
      check7("cyc_segOut", segOut, m_seg);
      check28("cyc_out_seg", out_seg, model_hist());
    end
  end

  task automatic step(input logic r, input logic u,
                      input logic [3:0] d);
    rst         = r;
    dif.updated = u;
    dif.DispVal = d;
    @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b1;
    rst         = 1'b1;
    dif.updated = 1'b0;
    dif.DispVal = 4'h0;
    @(negedge clk);

    // 1: reset
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    check7("rst_segOut", segOut, 7'h7F);
    check28("rst_out_seg", out_seg, 28'hFFFFFFF);

    // 2: decode all digits, no strobe
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i));
      check7("dec_lit", segOut, ref_lut[i]);
    end
    check7("dec_F_lit", segOut, 7'b0001110);
    check28("dec_hist_blank", out_seg, 28'hFFFFFFF);

    // 3: five pulses 0..4
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'(i));
      step(1'b0, 1'b0, 4'(i));
    end
    check28("push_1234", out_seg,
            {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    // 4: hold updated for 10 clocks with 7
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h7);
    check7("hold_newest", out_seg[6:0], 7'b1111000);
    check28("hold_once", out_seg,
            {7'b0100100, 7'b0110000, 7'b0011001, 7'b1111000});
    step(1'b0, 1'b0, 4'h7);

    // 5: reset on the rising edge of updated
    step(1'b1, 1'b1, 4'h5);
    check28("rst_push_blank", out_seg, 28'hFFFFFFF);
    check7("rst_push_seg", segOut, 7'h7F);

    // 6: updated held across reset release
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h9);
    check28("rel_no_shift", out_seg, 28'hFFFFFFF);
    check7("rel_seg", segOut, 7'b0010000);
    step(1'b0, 1'b0, 4'h9);
    step(1'b0, 1'b1, 4'hA);
    check28("rel_one_shift", out_seg,
            {7'h7F, 7'h7F, 7'h7F, 7'b0001000});
    step(1'b0, 1'b0, 4'hC);
    step(1'b0, 1'b1, 4'hd);
    check28("second_shift", out_seg,
            {7'h7F, 7'h7F, 7'b0001000, 7'b0100001});

    step(1'b0, 1'b0, 4'h0);
    chk_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
